// File: rtl/sig16b_conv_sched_pkg.sv
// Echo-cancel common definitions: sample/double widths, exponent bias and the
// scheduler FSM encoding.
package sig16b_conv_sched_pkg;

  localparam int DOUBLE_W = 64;
  localparam int SAMPLE_W = 16;
  localparam int BIAS     = 1023;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  function automatic logic [DOUBLE_W-1:0] signed_zero(input logic sign);
    return {sign, {(DOUBLE_W-1){1'b0}}};
  endfunction

endpackage

// File: rtl/sig16b_conv_sched_s2d.sv
// Iterative 16-bit sign-magnitude to IEEE-754 double converter: rst loads the
// sample, then one normalising left shift per cycle until stop (value = mag/2^14).
module sig16b_to_double
  import sig16b_conv_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] din,
  output logic [DOUBLE_W-1:0] dout,
  output logic                stop
);

  logic        sign_q, sign_d;
  logic [14:0] norm_q, norm_d;
  logic [10:0] exp_q,  exp_d;
  logic [3:0]  cnt_q,  cnt_d;

  // A zero magnitude never normalises; the shift counter bounds it to 15 steps.
  assign stop = norm_q[14] | (cnt_q == 4'd15);
  assign dout = {sign_q, exp_q, norm_q[13:0], 38'b0};

  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    sign_d = sign_q;
    norm_d = norm_q;
    exp_d  = exp_q;
    cnt_d  = cnt_q;
    if (rst) begin
      sign_d = din[15];
      norm_d = din[14:0];
      exp_d  = 11'(BIAS);
      cnt_d  = '0;
    end else if (!stop) begin
      norm_d = {norm_q[13:0], 1'b0};
      exp_d  = exp_q - 11'd1;
      cnt_d  = cnt_q + 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    sign_q <= sign_d;
    norm_q <= norm_d;
    exp_q  <= exp_d;
    cnt_q  <= cnt_d;
  end

endmodule

// File: rtl/sig16b_conv_sched.sv
// Round-robin scheduler sharing one sig16b_to_double converter among NCH
// sample streams, with signed-zero patch and a conversion watchdog.
module sig16b_conv_sched
  import sig16b_conv_sched_pkg::*;
#(
  parameter  int NCH     = 2,
  parameter  int TIMEOUT = 24,
  localparam int CW      = $clog2(NCH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          req_valid,
  input  logic [SAMPLE_W*NCH-1:0] req_data,
  output logic [NCH-1:0]          req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DOUBLE_W-1:0]     out_double,
  output logic [CW-1:0]           out_chan,
  output logic                    busy,
  output logic                    err_timeout
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       ptr_q, ptr_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic [CW-1:0]       chan_q, chan_d;
  logic [WDW-1:0]      wd_q, wd_d;
  logic [DOUBLE_W-1:0] out_double_q, out_double_d;
  logic [CW-1:0]       out_chan_q, out_chan_d;
  logic                err_q, err_d;

  logic                found;
  logic [CW-1:0]       grant, cand;
  logic                conv_rst, conv_stop;
  logic [DOUBLE_W-1:0] conv_dout;

  // Held in its load state throughout system reset and for the LOAD cycle.
  assign conv_rst = ~rst | (state_q == ST_LOAD);

  sig16b_to_double u_conv (
    .clk  (clk),
    .rst  (conv_rst),
    .din  (data_q),
    .dout (conv_dout),
    .stop (conv_stop)
  );

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = CW'((int'(ptr_q) + i) % NCH);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    data_d       = data_q;
    chan_d       = chan_q;
    wd_d         = wd_q;
    out_double_d = out_double_q;
    out_chan_d   = out_chan_q;
    err_d        = err_q;
    req_ready    = '0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          req_ready[grant] = 1'b1;
          data_d  = req_data[int'(grant)*SAMPLE_W +: SAMPLE_W];
          chan_d  = grant;
          ptr_d   = grant;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        wd_d    = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        wd_d = wd_q + WDW'(1);
        if (conv_stop) begin
          out_double_d = (data_q[14:0] == 15'd0) ? signed_zero(data_q[15]) : conv_dout;
          out_chan_d   = chan_q;
          state_d      = ST_HOLD;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (out_ready) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= CW'(NCH - 1);
      data_q       <= '0;
      chan_q       <= '0;
      wd_q         <= '0;
      out_double_q <= '0;
      out_chan_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      data_q       <= data_d;
      chan_q       <= chan_d;
      wd_q         <= wd_d;
      out_double_q <= out_double_d;
      out_chan_q   <= out_chan_d;
      err_q        <= err_d;
    end
  end

  assign out_valid   = (state_q == ST_HOLD);
  assign out_double  = out_double_q;
  assign out_chan    = out_chan_q;
  assign busy        = (state_q != ST_IDLE);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_sig16b_conv_sched.sv
// Scoreboard bench for sig16b_conv_sched: directed samples push expected
// results; an independent monitor checks latency, value and channel.
module tb_sig16b_conv_sched;

  localparam int TIMEOUT = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [31:0] req_data;
  logic [1:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_double;
  logic [0:0]  out_chan;
  logic        busy;
  logic        err_timeout;

  sig16b_conv_sched #(.NCH(2), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_double  (out_double),
    .out_chan    (out_chan),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          ch;
    logic [63:0] dbl;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [63:0] D_ONE    = 64'h3FF0_0000_0000_0000;  // 0x4000
  localparam logic [63:0] D_MAG1   = 64'h3F10_0000_0000_0000;  // 0x0001
  localparam logic [63:0] D_NEG3   = 64'hBF28_0000_0000_0000;  // 0x8003
  localparam logic [63:0] D_NEGZ   = 64'h8000_0000_0000_0000;  // 0x8000

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Starts at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int ch, input logic [15:0] d, input logic [63:0] exp,
                      input int lat, input bit expect_out, output int acc);
    bit got = 0;
    acc = -1;
    req_valid[ch] = 1'b1;
    req_data[ch*16 +: 16] = d;
    for (int t = 0; t < 200 && !got; t++) begin
      #1;
      if (req_ready[ch]) begin
        got = 1;
        acc = cyc + 1;
        if (expect_out) sb.push_back('{ch, exp, acc, lat});
      end
      @(negedge clk);
    end
    req_valid[ch] = 1'b0;
    check("accept", 64'(got), 64'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb.size() != 0; t++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset_state();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_double", out_double, 64'd0);
    check("rst_out_chan", 64'(out_chan), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err_timeout", 64'(err_timeout), 64'd0);
  endtask

  // Monitor: latency on out_valid rising, value/channel on each handshake.
  initial begin
    bit   prev_v = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_out: got %h with no pending request", out_double);
        end else begin
          check("latency", 64'(cyc - sb[0].acc + 1), 64'(sb[0].lat));
        end
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        check("out_double", out_double, e.dbl);
        check("out_chan", 64'(out_chan), 64'(e.ch));
      end
      prev_v = out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, n, g, exp_g, hit;
    rst = 1'b0;
    req_valid = '0;
    req_data = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_state();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single sample on ch0: 1.0 in three edges.
    send(0, 16'h4000, D_ONE, 3, 1, acc);
    drain();

    // Re-reset so the pointer again favours ch0, then contend.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    req_data = {16'h8003, 16'h0001};
    req_valid = 2'b11;
    n = 0;
    exp_g = 0;
    for (int t = 0; t < 400 && n < 4; t++) begin
      #1;
      if (req_ready != 2'b00) begin
        check("ready_onehot", 64'($countones(req_ready)), 64'd1);
        g = req_ready[1] ? 1 : 0;
        check("grant_order", 64'(g), 64'(exp_g));
        if (g == 1) sb.push_back('{1, D_NEG3, cyc + 1, 16});
        else        sb.push_back('{0, D_MAG1, cyc + 1, 17});
        exp_g = 1 - exp_g;
        n++;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    check("grant_count", 64'(n), 64'd4);
    drain();

    // Signed zeros via the zero patch.
    send(1, 16'h8000, D_NEGZ, 18, 1, acc);
    drain();
    send(1, 16'h0000, 64'd0, 18, 1, acc);
    drain();

    // Backpressure: HOLD persists, nothing else accepted.
    out_ready = 1'b0;
    send(0, 16'h4000, D_ONE, 3, 1, acc);
    for (int t = 0; t < 50 && !out_valid; t++) begin
      @(negedge clk);
      #1;
    end
    req_valid[1] = 1'b1;
    req_data[31:16] = 16'h4000;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_double", out_double, D_ONE);
      check("hold_chan", 64'(out_chan), 64'd0);
      check("hold_ready", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    check("release_busy", 64'(busy), 64'd0);
    check("release_valid", 64'(out_valid), 64'd0);
    drain();

    // Hung converter: watchdog fires TIMEOUT cycles after entering RUN.
    force dut.conv_stop = 1'b0;
    send(0, 16'h4000, 64'd0, 0, 0, acc);
    hit = -1;
    for (int t = 0; t < 100 && hit < 0; t++) begin
      #1;
      if (err_timeout) hit = cyc;
      else @(negedge clk);
    end
    check("timeout_cycle", 64'(hit), 64'(acc + 1 + TIMEOUT));
    check("timeout_idle", 64'(busy), 64'd0);
    @(negedge clk);
    release dut.conv_stop;
    send(1, 16'h8003, D_NEG3, 16, 1, acc);
    drain();
    check("timeout_sticky", 64'(err_timeout), 64'd1);

    // Reset in the middle of RUN.
    send(0, 16'h0001, D_MAG1, 17, 1, acc);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_reset_state();
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(0, 16'h4000, D_ONE, 3, 1, acc);
    drain();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sig16b_conv_sched.md
Name: sig16b_conv_sched

Overview:
- Round-robin scheduler that shares one sig16b_to_double converter among NCH 16-bit sign-magnitude sample streams (default 2: near-end mic and far-end reference).
- Accepts samples via valid/ready, starts the converter, waits for its done flag and returns the 64-bit double tagged with its channel id.
- Patches the converter's zero-input case and guards against a hung conversion with a watchdog.

Parameters:
- NCH, 2, number of requesting channels (>=2).
- TIMEOUT, 24, max cycles in RUN before abort (converter worst case is 16).
- CW, clog2(NCH), localparam, channel-id width.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset.
- req_valid  input  NCH  per-channel sample valid.
- req_data  input  16*NCH  channel k occupies bits [16k+15:16k]; bit 15 is sign, [14:0] is magnitude.
- req_ready  output  NCH  one-hot accept strobe.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_double  output  64  IEEE-754 double result.
- out_chan  output  CW  source channel of out_double.
- busy  output  1  state != IDLE.
- err_timeout  output  1  sticky watchdog flag.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state goes to IDLE; out_valid=0, out_double=0, out_chan=0, err_timeout=0, busy=0.
  - Round-robin pointer is set to NCH-1, so channel 0 has first priority.
  - The converter start line is asserted while rst==0, which re-initialises the converter mid-operation.
- FSM states IDLE, LOAD, RUN, HOLD:
  - IDLE: grant = the first channel with req_valid set, searching from pointer+1 modulo NCH. req_ready[grant]=1 combinationally, and only in IDLE. On acceptance: latch data and channel, update pointer to grant, go to LOAD. If no valid request, stay in IDLE.
  - LOAD: one cycle with converter start=1 and converter input = latched data; clear the watchdog counter; go to RUN.
  - RUN: converter start=0; increment the watchdog each cycle.
    - If converter stop==1: capture the result into out_double/out_chan, go to HOLD.
    - Else if watchdog==TIMEOUT-1: set err_timeout, drop the sample, go to IDLE.
  - HOLD: out_valid=1 and out_double/out_chan stable; on out_ready go to IDLE.
- Zero fix: if the latched magnitude [14:0]==0, out_double = {sign,63'b0} (signed zero). The converter's own output is ignored in this case, but the conversion still runs to stop.
- Latency, counted in edges from the acceptance edge to out_valid rising:
  - 3 for magnitude >= 0x4000.
  - 3+n for a magnitude whose leading one is n positions below bit 14.
  - 18 for zero magnitude.
  - Max throughput is one sample per latency+1 cycles (IDLE re-entry costs one cycle).
- Backpressure: if out_ready stays low, HOLD persists indefinitely; no further requests are accepted.
- Simultaneous requests: exactly one grant per IDLE cycle. Non-granted channels must hold valid and data (standard valid/ready).
- err_timeout is cleared only by reset.

Decomposition:
- Shared package (echo-cancel common): DOUBLE_W=64, SAMPLE_W=16, exponent BIAS=1023, FSM state encoding.
- One sub-module: instantiate the existing sig16b_to_double.
  - Its active-high rst is driven as (~rst | state==LOAD).
  - Its stop output feeds RUN.
- The round-robin grant is inline logic. It may be split out as rr_arbiter, NCH-parameterised, if reused later.

Test Plan:
- Reset then ch0 valid with data 0x4000 -> req_ready[0] at acceptance; out_valid 3 edges later; out_double=0x3FF0000000000000 (1.0 under the converter's scaling); out_chan=0.
- Both channels valid continuously: ch0 0x0001, ch1 0x8003 -> grants alternate 0,1,0,1. ch1 result has sign bit 1; ch0 result has exponent 1023-14 and latency 17.
- ch1 data 0x8000 -> out_double=0x8000000000000000; ch1 data 0x0000 -> 0x0. Both latency 18.
- Hold out_ready=0 for 50 cycles in HOLD -> out_valid stays 1; data and channel stable; req_ready all 0; release -> IDLE next cycle.
- Force converter stop stuck at 0 -> err_timeout=1 exactly TIMEOUT cycles after entering RUN; FSM back to IDLE; next request processed normally.
- Pull rst low during RUN -> all outputs 0 next edge. After release, a new 0x4000 request converts correctly in 3 edges.
